// File: rtl/instr_encoder_loader_if.sv
// Loader handshake bundle: field input, IMEM write
// port and session status.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              finish;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_type;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        err_count;
  logic [ADDR_W:0]   word_count;

  modport master (
    output start, finish, in_valid,
    output in_type, in_opcode, in_funct3,
    output in_funct7, in_rs1, in_rs2,
    output in_rd, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr,
    input  mem_wdata, busy, done, err,
    input  err_count, word_count
  );

  modport slave (
    input  start, finish, in_valid,
    input  in_type, in_opcode, in_funct3,
    input  in_funct7, in_rs1, in_rs2,
    input  in_rd, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr,
    output mem_wdata, busy, done, err,
    output err_count, word_count
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32I field encoder streaming legal words into
// consecutive IMEM addresses; illegal words dropped.
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input logic clk,
  input logic rst_n,
  instr_encoder_loader_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LP_MAX  = '1;
  localparam logic [ADDR_W-1:0] LP_BASE =
    ADDR_W'(BASE_ADDR);

  state_t            r_state;
  logic              r_ov;
  logic [ADDR_W-1:0] r_ptr;
  logic [31:0]       r_wdata;
  logic              r_full;
  logic              r_err;
  logic [7:0]        r_ecnt;
  logic [ADDR_W:0]   r_wcnt;

  logic        w_full;
  logic        w_load;
  logic        w_rdy;
  logic        w_acc;
  logic        w_wr;
  logic        w_legal;
  logic [31:0] w_enc;
  logic        w_fit12;
  logic        w_fit13;
  logic        w_fit21;
  logic        w_op_i;
  logic [31:0] w_imm;
  logic [6:0]  w_op;

  assign w_imm = bus.in_imm;
  assign w_op  = bus.in_opcode;

  // A pending word at the last address counts as full
  assign w_full = r_full |
    (r_ov & (r_ptr == LP_MAX));
  assign w_load = (r_state == S_LOAD);
  assign w_rdy  = w_load & ~w_full &
    (~r_ov | bus.mem_ready);
  assign w_acc  = bus.in_valid & w_rdy;
  assign w_wr   = r_ov & bus.mem_ready;

  assign w_fit12 = (&w_imm[31:11]) |
    ~(|w_imm[31:11]);
  assign w_fit13 = (&w_imm[31:12]) |
    ~(|w_imm[31:12]);
  assign w_fit21 = (&w_imm[31:20]) |
    ~(|w_imm[31:20]);
  assign w_op_i = (w_op == 7'b0000011) |
    (w_op == 7'b0001111) |
    (w_op == 7'b0010011) |
    (w_op == 7'b1100111) |
    (w_op == 7'b1110011);

  // Encode the fields and judge legality by type
  always_comb begin
    w_enc   = '0;
    w_legal = 1'b0;
    unique case (1'b1)
      (bus.in_type == 3'd0): begin
        w_enc = {bus.in_funct7, bus.in_rs2,
          bus.in_rs1, bus.in_funct3,
          bus.in_rd, w_op};
        w_legal = (w_op == 7'b0110011);
      end
      (bus.in_type == 3'd1): begin
        w_enc = {w_imm[11:0], bus.in_rs1,
          bus.in_funct3, bus.in_rd, w_op};
        w_legal = w_op_i & w_fit12;
      end
      (bus.in_type == 3'd2): begin
        w_enc = {w_imm[11:5], bus.in_rs2,
          bus.in_rs1, bus.in_funct3,
          w_imm[4:0], w_op};
        w_legal = (w_op == 7'b0100011) & w_fit12;
      end
      (bus.in_type == 3'd3): begin
        w_enc = {w_imm[12], w_imm[10:5],
          bus.in_rs2, bus.in_rs1,
          bus.in_funct3, w_imm[4:1],
          w_imm[11], w_op};
        w_legal = (w_op == 7'b1100011) &
          w_fit13 & ~w_imm[0];
      end
      (bus.in_type == 3'd4): begin
        w_enc = {w_imm[19:0], bus.in_rd, w_op};
        w_legal = ((w_op == 7'b0010111) |
          (w_op == 7'b0110111)) &
          ~(|w_imm[31:20]);
      end
      (bus.in_type == 3'd5): begin
        w_enc = {w_imm[20], w_imm[10:1],
          w_imm[11], w_imm[19:12],
          bus.in_rd, w_op};
        w_legal = (w_op == 7'b1101111) &
          w_fit21 & ~w_imm[0];
      end
      default: begin
        w_enc   = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  // Session FSM, output register, pointer and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ov    <= 1'b0;
      r_ptr   <= LP_BASE;
      r_wdata <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_ecnt  <= '0;
      r_wcnt  <= '0;
    end else begin
      if (w_wr) begin
        r_ov   <= 1'b0;
        r_wcnt <= r_wcnt + 1'b1;
        if (r_ptr == LP_MAX) r_full <= 1'b1;
        else r_ptr <= r_ptr + 1'b1;
      end
      if (w_acc) begin
        if (w_legal) begin
          r_ov    <= 1'b1;
          r_wdata <= w_enc;
        end else begin
          r_err <= 1'b1;
          if (r_ecnt != 8'hFF)
            r_ecnt <= r_ecnt + 8'd1;
        end
      end
      if (w_load & bus.in_valid & w_full)
        r_err <= 1'b1;
      unique case (r_state)
        S_IDLE: if (bus.start) begin
          r_state <= S_LOAD;
          r_err   <= 1'b0;
          r_ecnt  <= '0;
          r_wcnt  <= '0;
          r_ptr   <= LP_BASE;
          r_full  <= 1'b0;
        end
        S_LOAD:
          if (bus.finish) r_state <= S_DRAIN;
        S_DRAIN:
          if (!r_ov) r_state <= S_DONE;
        S_DONE:
          r_state <= S_IDLE;
        default:
          r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_rdy;
  assign bus.mem_we     = r_ov;
  assign bus.mem_addr   = r_ov ? r_ptr : '0;
  assign bus.mem_wdata  = r_wdata;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_DONE);
  assign bus.err        = r_err;
  assign bus.err_count  = r_ecnt;
  assign bus.word_count = r_wcnt;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed bench for the encoder/loader
// against a session-level scoreboard model.
module tb_instr_encoder_loader;
  localparam int AW  = 2;
  localparam int CAP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_W(AW)) bus();

  instr_encoder_loader #(
    .ADDR_W(AW),
    .BASE_ADDR(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int n_chk = 0;
  int n_err = 0;

  int mst = 0;
  int n_leg = 0;
  int n_wr = 0;
  int n_ecnt = 0;
  bit m_err = 0;
  wr_t q[$];
  logic [31:0] imem [CAP];
  logic [31:0] last_wd;
  logic [31:0] last_wa;
  bit last_acc;
  bit last_done;
  bit rnd_mr = 0;

  task automatic chk(string tag,
                     logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
        tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_enc(
    input logic [2:0] t, input logic [6:0] op,
    input logic [2:0] f3, input logic [6:0] f7,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic [4:0] rd, input logic [31:0] im);
    case (t)
      3'd0: return {f7, r2, r1, f3, rd, op};
      3'd1: return {im[11:0], r1, f3, rd, op};
      3'd2: return {im[11:5], r2, r1, f3,
                    im[4:0], op};
      3'd3: return {im[12], im[10:5], r2, r1, f3,
                    im[4:1], im[11], op};
      3'd4: return {im[19:0], rd, op};
      3'd5: return {im[20], im[10:1], im[11],
                    im[19:12], rd, op};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_legal(
    input logic [2:0] t, input logic [6:0] op,
    input logic [31:0] im);
    int s;
    s = int'($signed(im));
    case (t)
      3'd0: return op == 7'h33;
      3'd1: return (op == 7'h03 || op == 7'h0F ||
        op == 7'h13 || op == 7'h67 ||
        op == 7'h73) && s >= -2048 && s <= 2047;
      3'd2: return op == 7'h23 &&
        s >= -2048 && s <= 2047;
      3'd3: return op == 7'h63 && im[0] == 1'b0 &&
        s >= -4096 && s <= 4095;
      3'd4: return (op == 7'h17 || op == 7'h37) &&
        im[31:20] == 12'h0;
      3'd5: return op == 7'h6F && im[0] == 1'b0 &&
        s >= -(1 << 20) && s < (1 << 20);
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    bit fullm;
    bit exp_rdy;
    int qs0;
    wr_t w;
    if (rnd_mr) bus.mem_ready = 1'($urandom_range(0, 1));
    #1;
    qs0 = q.size();
    fullm = (n_leg >= CAP);
    exp_rdy = (mst == 1) && !fullm &&
      (qs0 == 0 || bus.mem_ready);
    chk("busy", bus.busy, 64'(mst != 0));
    chk("done", bus.done, 64'(mst == 3));
    chk("in_ready", bus.in_ready, 64'(exp_rdy));
    chk("mem_we", bus.mem_we, 64'(qs0 != 0));
    chk("err", bus.err, 64'(m_err));
    chk("err_count", bus.err_count, 64'(n_ecnt));
    chk("word_count", bus.word_count, 64'(n_wr));
    if (qs0 != 0 && bus.mem_we) begin
      chk("mem_addr", bus.mem_addr, 64'(q[0].a));
      chk("mem_wdata", bus.mem_wdata, 64'(q[0].d));
    end
    last_acc  = bus.in_valid && bus.in_ready;
    last_done = bus.done;
    if (bus.mem_we && bus.mem_ready) begin
      last_wd = bus.mem_wdata;
      last_wa = 32'(bus.mem_addr);
      imem[bus.mem_addr] = bus.mem_wdata;
    end
    if (rst_n) begin
      if (qs0 != 0 && bus.mem_ready) begin
        void'(q.pop_front());
        n_wr++;
      end
      case (mst)
        0: if (bus.start) begin
          mst = 1; n_leg = 0; n_wr = 0;
          n_ecnt = 0; m_err = 0;
        end
        1: begin
          if (bus.in_valid && exp_rdy) begin
            if (m_legal(bus.in_type, bus.in_opcode,
                        bus.in_imm)) begin
              w.a = 32'(n_leg);
              w.d = m_enc(bus.in_type, bus.in_opcode,
                bus.in_funct3, bus.in_funct7,
                bus.in_rs1, bus.in_rs2, bus.in_rd,
                bus.in_imm);
              q.push_back(w);
              n_leg++;
            end else begin
              m_err = 1;
              if (n_ecnt < 255) n_ecnt++;
            end
          end
          if (bus.in_valid && fullm) m_err = 1;
          if (bus.finish) mst = 2;
        end
        2: if (qs0 == 0) mst = 3;
        default: mst = 0;
      endcase
    end
    @(posedge clk);
    if (!rst_n) begin
      mst = 0; q.delete(); n_leg = 0; n_wr = 0;
      n_ecnt = 0; m_err = 0;
    end
    @(negedge clk);
  endtask

  task automatic send(input int t, input int op,
    input int f3, input int f7, input int r1,
    input int r2, input int rd,
    input logic [31:0] im, input int budget,
    output bit acc);
    bus.in_type   = 3'(t);
    bus.in_opcode = 7'(op);
    bus.in_funct3 = 3'(f3);
    bus.in_funct7 = 7'(f7);
    bus.in_rs1    = 5'(r1);
    bus.in_rs2    = 5'(r2);
    bus.in_rd     = 5'(rd);
    bus.in_imm    = im;
    bus.in_valid  = 1'b1;
    acc = 0;
    for (int i = 0; i < budget && !acc; i++) begin
      tick();
      acc = last_acc;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic begin_session();
    for (int i = 0; i < CAP; i++) imem[i] = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic end_session();
    bit saw;
    saw = 0;
    bus.finish = 1'b1;
    tick();
    bus.finish = 1'b0;
    for (int i = 0; i < 40 && !saw; i++) begin
      tick();
      saw = last_done;
    end
    chk("done_seen", 64'(saw), 64'd1);
  endtask

  function automatic int pick_op(input int t);
    int ops_i [5];
    ops_i = '{7'h03, 7'h0F, 7'h13, 7'h67, 7'h73};
    case (t)
      0: return 7'h33;
      1: return ops_i[$urandom_range(0, 4)];
      2: return 7'h23;
      3: return 7'h63;
      4: return $urandom_range(0, 1) ? 7'h17 : 7'h37;
      5: return 7'h6F;
      default: return 7'h13;
    endcase
  endfunction

  function automatic logic [31:0] pick_imm(input int t);
    logic [31:0] bnd [11];
    logic [31:0] v;
    bnd = '{32'd2047, -32'sd2048, 32'd2048,
            32'd4094, -32'sd4096, 32'd4096,
            32'd1048574, -32'sd1048576,
            32'd1048576, 32'h000FFFFF,
            32'h00100000};
    case ($urandom_range(0, 2))
      0: v = 32'($urandom_range(0, 200)) - 32'd100;
      1: v = $urandom;
      default: v = bnd[$urandom_range(0, 10)];
    endcase
    if ((t == 3 || t == 5) && $urandom_range(0, 3) != 0)
      v[0] = 1'b0;
    if (t == 4 && $urandom_range(0, 1) != 0)
      v[31:20] = '0;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int t;
    bus.start = 0; bus.finish = 0; bus.in_valid = 0;
    bus.in_type = 0; bus.in_opcode = 0;
    bus.in_funct3 = 0; bus.in_funct7 = 0;
    bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0;
    bus.in_imm = 0; bus.mem_ready = 1;
    last_wd = 0; last_wa = 0;
    @(negedge clk);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_addr", bus.mem_addr, 64'd0);
    chk("rst_wdata", bus.mem_wdata, 64'd0);

    begin_session();
    send(1, 7'h13, 0, 0, 0, 0, 1, 32'd5, 10, acc);
    chk("addi_acc", 64'(acc), 64'd1);
    tick();
    chk("addi_data", last_wd, 64'h00500093);
    chk("addi_addr", last_wa, 64'd0);
    chk("addi_wc", bus.word_count, 64'd1);
    end_session();

    begin_session();
    send(3, 7'h63, 0, 0, 1, 2, 0, -32'sd8, 10, acc);
    bus.mem_ready = 1'b0;
    send(2, 7'h23, 2, 0, 1, 2, 0, 32'd4, 3, acc);
    chk("stall_acc", 64'(acc), 64'd0);
    bus.mem_ready = 1'b1;
    send(2, 7'h23, 2, 0, 1, 2, 0, 32'd4, 10, acc);
    chk("sw_acc", 64'(acc), 64'd1);
    tick();
    chk("beq_word", imem[0], 64'hFE208CE3);
    chk("sw_word", imem[1], 64'h0020A223);
    end_session();

    begin_session();
    send(3, 7'h63, 0, 0, 1, 2, 0, 32'd3, 10, acc);
    send(1, 7'h13, 0, 0, 1, 0, 3, 32'd2048, 10, acc);
    tick();
    chk("ill_cnt", bus.err_count, 64'd2);
    chk("ill_err", bus.err, 64'd1);
    send(1, 7'h13, 0, 0, 0, 0, 1, 32'd5, 10, acc);
    tick();
    chk("ill_next_addr", last_wa, 64'd0);
    end_session();

    begin_session();
    for (int i = 0; i < 4; i++) begin
      send(5, 7'h6F, 0, 0, 0, 0, 1, 32'd16, 10, acc);
      chk("jal_acc", 64'(acc), 64'd1);
    end
    send(5, 7'h6F, 0, 0, 0, 0, 1, 32'd16, 4, acc);
    chk("jal5_stall", 64'(acc), 64'd0);
    chk("jal5_err", bus.err, 64'd1);
    end_session();
    chk("jal_wc", bus.word_count, 64'd4);
    for (int i = 0; i < CAP; i++)
      chk("jal_word", imem[i], 64'h010000EF);

    begin_session();
    bus.mem_ready = 1'b0;
    send(1, 7'h13, 0, 0, 0, 0, 1, 32'd5, 10, acc);
    tick();
    chk("pre_rst_we", bus.mem_we, 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    chk("post_rst_addr", bus.mem_addr, 64'd0);
    chk("post_rst_wdata", bus.mem_wdata, 64'd0);
    begin_session();
    send(1, 7'h13, 0, 0, 0, 0, 1, 32'd5, 10, acc);
    tick();
    chk("post_rst_wa", last_wa, 64'd0);
    end_session();

    rnd_mr = 1;
    for (int s = 0; s < 12; s++) begin
      begin_session();
      for (int k = 0; k < 6; k++) begin
        t = $urandom_range(0, 6);
        send(t,
          ($urandom_range(0, 3) != 0) ? pick_op(t)
                                      : int'($urandom),
          $urandom, $urandom, $urandom, $urandom,
          $urandom, pick_imm(t), 8, acc);
        if ($urandom_range(0, 2) == 0) tick();
      end
      end_session();
    end

    $display("Result: errors=%0d of %0d checks",
      n_err, n_chk);
    $finish;
  end
endmodule
